gf180mcu_fd_sc_mcu9t5v0__nand3_bist: RTL and testbench
======================================================

GF180MCU_FD_SC_MCU9T5V0__NAND3_BIST -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__nand3_bist

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning the number of extra hold cycles per vector before ZN is sampled (legal range 0..15).
REQ-002 SHALL have parameter LOOPS, default 1, meaning the number of full 8-vector sweeps per run (legal range 1..255).
REQ-003 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port RN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  run request, sampled in IDLE only.
REQ-006 SHALL have port ZN  input  1  output of the NAND3 cell under test.
REQ-007 SHALL have ports A1, A2, A3  output  1 each  drive the inputs of the cell under test.
REQ-008 SHALL have port BUSY  output  1  high while a run is in progress.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse at run completion.
REQ-010 SHALL have port PASS  output  1  result of the last completed run (1 = no mismatch).
REQ-011 SHALL have port ERR_CNT  output  4  saturating mismatch count of the current or last run.
REQ-012 SHALL have port FAIL_VLD  output  1  high once any mismatch has been captured in the current or last run.
REQ-013 SHALL have port FAIL_VEC  output  3  vector {A3,A2,A1} of the first mismatch.

Function
REQ-014 SHALL implement the states IDLE, RUN and FINISH.
REQ-015 In IDLE with START=1 at edge k, the block SHALL enter RUN with vector 0, hold counter 0 and loop counter 0, set BUSY=1, and clear ERR_CNT, FAIL_VLD, FAIL_VEC and PASS.
REQ-016 In RUN, {A3,A2,A1} SHALL equal the current vector; the vector SHALL advance in the order 0,1,...,7 and wrap to 0 at the start of the next loop.
REQ-017 Each vector SHALL be held for SETTLE+1 cycles, and ZN SHALL be sampled on the edge where the hold counter equals SETTLE.
REQ-018 The expected value SHALL be NOT(A1 AND A2 AND A3); a mismatch SHALL be any sampled ZN unequal to it, with X or Z counted as a mismatch.
REQ-019 On a mismatch, ERR_CNT SHALL increment and saturate at 15; on the first mismatch only, FAIL_VEC SHALL capture the vector and FAIL_VLD SHALL be set.
REQ-020 The sample edge of vector 7 in loop LOOPS-1 (edge k+8*LOOPS*(SETTLE+1)) SHALL move the block to FINISH, set BUSY=0 and DONE=1, and set PASS=1 if the final error count, including that sample, is 0.
REQ-021 FINISH SHALL last exactly one cycle; the block SHALL then return to IDLE with DONE=0.
REQ-022 In IDLE and FINISH, A1, A2 and A3 SHALL be driven to 0.
REQ-023 START SHALL be ignored in RUN and FINISH; a START held high SHALL be accepted on the first IDLE cycle after FINISH.
REQ-024 ERR_CNT, FAIL_VLD, FAIL_VEC and PASS SHALL hold their values in IDLE until the next accepted START.

Reset
REQ-025 RN=0 SHALL immediately (asynchronously) force IDLE, A1=A2=A3=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VLD=0 and FAIL_VEC=0, including in the middle of a run.
REQ-026 After RN returns high, the block SHALL accept START no earlier than the first rising edge with RN=1, and an aborted run SHALL NOT produce DONE.

Verification
REQ-027 Correct NAND3 model, SETTLE=2, LOOPS=1, START pulse at edge k -> BUSY high edges k..k+23, DONE at edge k+24, PASS=1, ERR_CNT=0, FAIL_VLD=0.
REQ-028 ZN stuck at 1, SETTLE=2, LOOPS=1 -> ERR_CNT=1, FAIL_VEC=7, FAIL_VLD=1, PASS=0.
REQ-029 ZN stuck at 0, SETTLE=0, LOOPS=3 -> 21 raw mismatches, ERR_CNT saturates at 15, FAIL_VEC=0, DONE at edge k+24.
REQ-030 RN pulsed low during vector 4 of a run -> all outputs immediately at reset values, no DONE; a new START then runs to completion with PASS=1.
REQ-031 START held continuously high -> back-to-back runs separated by exactly one FINISH cycle and one IDLE cycle; START pulses during RUN have no effect.
REQ-032 ZN driven X only on vector 3 -> ERR_CNT=1, FAIL_VEC=3, PASS=0.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_bist.sv
// Built-in self-test for a NAND3 standard cell: sweeps all eight input
// vectors, compares ZN against the NAND3 truth table and records the result.
module gf180mcu_fd_sc_mcu9t5v0__nand3_bist #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned LOOPS  = 1
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       START,
  input  logic       ZN,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic       FAIL_VLD,
  output logic [2:0] FAIL_VEC
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] vec_q;
  logic [3:0] hold_q;
  logic [7:0] loop_q;
  logic [3:0] err_q, err_d;
  logic       fail_vld_q;
  logic [2:0] fail_vec_q;
  logic       pass_q;

  logic exp_zn;
  logic sample;
  logic mismatch;
  logic last;

  assign exp_zn = ~(vec_q[0] & vec_q[1] & vec_q[2]);
  assign sample = (state_q == RUN) && (hold_q == 4'(SETTLE));
  // Case inequality so an X or Z on ZN is treated as a failure.
  assign mismatch = sample && (ZN !== exp_zn);
  assign last     = sample && (vec_q == 3'd7) && (loop_q == 8'(LOOPS - 1));

  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != 4'd15)) begin
      err_d = err_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = RUN;
      RUN:     if (last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      hold_q     <= '0;
      loop_q     <= '0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      fail_vec_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (START) begin
            vec_q      <= '0;
            hold_q     <= '0;
            loop_q     <= '0;
            err_q      <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
            pass_q     <= 1'b0;
          end
        end
        RUN: begin
          if (sample) begin
            hold_q <= '0;
            vec_q  <= vec_q + 3'd1;
            if (vec_q == 3'd7) begin
              loop_q <= loop_q + 8'd1;
            end
            err_q <= err_d;
            if (mismatch && !fail_vld_q) begin
              fail_vld_q <= 1'b1;
              fail_vec_q <= vec_q;
            end
            if (last) begin
              pass_q <= (err_d == 4'd0);
            end
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status and stimulus decode straight from state so reset clears them at once.
  assign {A3, A2, A1} = (state_q == RUN) ? vec_q : 3'b000;
  assign BUSY         = (state_q == RUN);
  assign DONE         = (state_q == FINISH);
  assign PASS         = pass_q;
  assign ERR_CNT      = err_q;
  assign FAIL_VLD     = fail_vld_q;
  assign FAIL_VEC     = fail_vec_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nand3_bist.sv
// Randomised bench for the NAND3 BIST: two instances with different sweep
// parameters, a per-vector fault table driving ZN, and a sweep-level model.
module tb_gf180mcu_fd_sc_mcu9t5v0__nand3_bist;

  localparam int unsigned SA = 2, LA = 1;
  localparam int unsigned SB = 0, LB = 3;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic zn_a, zn_b;
  logic a1_a, a2_a, a3_a, busy_a, done_a, pass_a, fvld_a;
  logic a1_b, a2_b, a3_b, busy_b, done_b, pass_b, fvld_b;
  logic [3:0] err_a, err_b;
  logic [2:0] fvec_a, fvec_b;

  // fault code per vector: 0 good, 1 stuck-0, 2 stuck-1, 3 X
  logic [1:0] fault [2][8];
  int cur = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__nand3_bist #(.SETTLE(SA), .LOOPS(LA)) dut_a (
    .CLK(clk), .RN(rn), .START(start_a), .ZN(zn_a),
    .A1(a1_a), .A2(a2_a), .A3(a3_a), .BUSY(busy_a), .DONE(done_a),
    .PASS(pass_a), .ERR_CNT(err_a), .FAIL_VLD(fvld_a), .FAIL_VEC(fvec_a)
  );

  gf180mcu_fd_sc_mcu9t5v0__nand3_bist #(.SETTLE(SB), .LOOPS(LB)) dut_b (
    .CLK(clk), .RN(rn), .START(start_b), .ZN(zn_b),
    .A1(a1_b), .A2(a2_b), .A3(a3_b), .BUSY(busy_b), .DONE(done_b),
    .PASS(pass_b), .ERR_CNT(err_b), .FAIL_VLD(fvld_b), .FAIL_VEC(fvec_b)
  );

  function automatic logic zval(input logic [1:0] code, input logic [2:0] v);
    case (code)
      2'd0:    return ~&v;
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return 1'bx;
    endcase
  endfunction

  always_comb zn_a = zval(fault[0][{a3_a, a2_a, a1_a}], {a3_a, a2_a, a1_a});
  always_comb zn_b = zval(fault[1][{a3_b, a2_b, a1_b}], {a3_b, a2_b, a1_b});

  logic [2:0] a_m, fvec_m;
  logic [3:0] err_m;
  logic       busy_m, done_m, pass_m, fvld_m;
  always_comb begin
    if (cur == 0) begin
      a_m = {a3_a, a2_a, a1_a}; busy_m = busy_a; done_m = done_a;
      pass_m = pass_a; err_m = err_a; fvld_m = fvld_a; fvec_m = fvec_a;
    end else begin
      a_m = {a3_b, a2_b, a1_b}; busy_m = busy_b; done_m = done_b;
      pass_m = pass_b; err_m = err_b; fvld_m = fvld_b; fvec_m = fvec_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: walk every sample of every loop and apply the NAND3 rule.
  task automatic predict(input int s, output logic [3:0] ec, output logic fv,
                         output logic [2:0] fvec, output logic pass);
    int raw = 0;
    int loops = (s == 0) ? LA : LB;
    fv = 1'b0;
    fvec = '0;
    for (int l = 0; l < loops; l++) begin
      for (int v = 0; v < 8; v++) begin
        logic [2:0] vv = 3'(v);
        if (zval(fault[s][v], vv) !== ~&vv) begin
          if (!fv) begin
            fv = 1'b1;
            fvec = vv;
          end
          raw++;
        end
      end
    end
    ec = (raw > 15) ? 4'd15 : 4'(raw);
    pass = (raw == 0);
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start_a = v; else start_b = v;
  endtask

  task automatic check_results(input string tag, input logic [3:0] ec, input logic fv,
                               input logic [2:0] fvec, input logic pass);
    check({tag, "_pass"}, 32'(pass_m), 32'(pass));
    check({tag, "_err"}, 32'(err_m), 32'(ec));
    check({tag, "_fvld"}, 32'(fvld_m), 32'(fv));
    check({tag, "_fvec"}, 32'(fvec_m), 32'(fvec));
  endtask

  // Starts a run on instance s (must be idle) and checks it cycle by cycle.
  task automatic run_check(input int s, input bit noisy_start);
    int st = (s == 0) ? SA : SB;
    int n = 8 * ((s == 0) ? LA : LB) * (st + 1);
    logic [3:0] ec;
    logic fv, pass;
    logic [2:0] fvec;
    cur = s;
    predict(s, ec, fv, fvec, pass);
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    for (int c = 0; c < n; c++) begin
      check("busy", 32'(busy_m), 32'd1);
      check("vec", 32'(a_m), 32'((c / (st + 1)) % 8));
      if (noisy_start && c < n - 1) set_start(s, 1'($urandom));
      else set_start(s, 1'b0);
      @(posedge clk); #1;
    end
    check("done", 32'(done_m), 32'd1);
    check("busy_fin", 32'(busy_m), 32'd0);
    check("vec_fin", 32'(a_m), 32'd0);
    check_results("fin", ec, fv, fvec, pass);
    @(posedge clk); #1;
    check("done_clr", 32'(done_m), 32'd0);
    check("busy_idle", 32'(busy_m), 32'd0);
    check_results("idle", ec, fv, fvec, pass);
  endtask

  task automatic set_faults(input int s, input logic [1:0] code);
    for (int v = 0; v < 8; v++) fault[s][v] = code;
  endtask

  initial begin
    int cnt;
    bit seen;
    set_faults(0, 2'd0);
    set_faults(1, 2'd0);
    #12;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    rn = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_check(0, 1'b0);
    check("good_pass", 32'(pass_a), 32'd1);
    set_faults(0, 2'd2);
    run_check(0, 1'b0);
    check("stuck1_fvec", 32'(fvec_a), 32'd7);
    set_faults(1, 2'd1);
    run_check(1, 1'b0);
    check("stuck0_sat", 32'(err_b), 32'd15);
    set_faults(0, 2'd0);
    fault[0][3] = 2'd3;
    run_check(0, 1'b0);

    // Randomised fault tables and START noise during RUN
    for (int it = 0; it < 12; it++) begin
      int s = int'($urandom_range(1, 0));
      for (int v = 0; v < 8; v++)
        fault[s][v] = ($urandom_range(2, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
      run_check(s, 1'b1);
    end

    // Asynchronous reset in the middle of vector 4
    cur = 0;
    set_faults(0, 2'd0);
    fault[0][1] = 2'd1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("pre_rst_vec", 32'(a_m), 32'd4);
    #2 rn = 1'b0;
    #1;
    check("ar_busy", 32'(busy_a), 32'd0);
    check("ar_done", 32'(done_a), 32'd0);
    check("ar_vec", 32'({a3_a, a2_a, a1_a}), 32'd0);
    check("ar_err", 32'(err_a), 32'd0);
    check("ar_fvld", 32'(fvld_a), 32'd0);
    check("ar_fvec", 32'(fvec_a), 32'd0);
    check("ar_pass", 32'(pass_a), 32'd0);
    rn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) seen = 1'b1;
    end
    check("ar_no_done", 32'(seen), 32'd0);
    set_faults(0, 2'd0);
    run_check(0, 1'b0);

    // START held high: back-to-back runs with one FINISH and one IDLE cycle
    start_a = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      cnt = 0;
      while (!done_a && cnt < 200) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("held_len", 32'(cnt), 32'(8 * LA * (SA + 1)));
      @(posedge clk); #1;
      check("held_idle_busy", 32'(busy_a), 32'd0);
      check("held_idle_done", 32'(done_a), 32'd0);
      @(posedge clk); #1;
      check("held_restart", 32'(busy_a), 32'd1);
      check("held_vec0", 32'({a3_a, a2_a, a1_a}), 32'd0);
    end
    start_a = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("held_end_idle", 32'(busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
